kth_apb_responder: RTL and testbench
====================================

KTH_APB_RESPONDER -- requirements
Module: kth_apb_responder

Interface
REQ-001 SHALL have parameter INSTR_BASE_ADDR, default 32'h0000_0000, base of the write-only instruction window (4 KiB).
REQ-002 SHALL have parameter DATA_IN_BASE_ADDR, default 32'h0000_1000, base of the write-only input-buffer window (4 KiB).
REQ-003 SHALL have parameter DATA_OUT_BASE_ADDR, default 32'h0000_2000, base of the read-only output-buffer window (4 KiB).
REQ-004 SHALL have parameter CTRL_BASE_ADDR, default 32'h0000_3000, base of 4 control words: +0 cell select, +4 call, +8 status, +C irq enable.
REQ-005 SHALL have ports: clk_in in 1, the single clock; reset_int in 1, asynchronous active-high reset.
REQ-006 SHALL have APB3 slave ports: PADDR in 32; PSEL in 1; PENABLE in 1; PWRITE in 1; PWDATA in 32; PRDATA out 32; PREADY out 1; PSLVERR out 1.
REQ-007 SHALL have ports: instr_wr_en out 1; instr_wr_addr out 10 (word index); instr_wr_data out 32; cell_row out 8; cell_col out 8.
REQ-008 SHALL have ports: din_wr_en out 1; din_wr_addr out 7 (line index); din_wr_data out 256.
REQ-009 SHALL have ports: dout_rd_en out 1; dout_rd_addr out 7; dout_rd_data in 256, valid one cycle after dout_rd_en.
REQ-010 SHALL have ports: call out 1 (one-cycle pulse); ret in 1 (pulse from fabric); irq out 1.

Function
REQ-011 Transfer completes on a cycle with PSEL=1, PENABLE=1, PREADY=1; all write side effects SHALL happen on that cycle's rising edge only.
REQ-012 PREADY SHALL be 1 except during output-buffer miss wait states.
REQ-013 Unmapped address, write to DATA_OUT window, or write to status word SHALL complete with PSLVERR=1, PRDATA=0 and no side effect; PSLVERR=0 otherwise.
REQ-014 Instruction write: instr_wr_en=1 for exactly the completing cycle, instr_wr_addr=PADDR[11:2] relative to base, instr_wr_data=PWDATA.
REQ-015 Input-buffer write: word PADDR[4:2] stored in a 256-bit staging register at bits [32*w+:32]; when w=7, din_wr_en pulses one cycle later with din_wr_addr=PADDR[11:5] and the full staging value including the new word.
REQ-016 Staging register SHALL NOT clear after commit; rewriting only word 7 recommits the retained words 0-6.
REQ-017 Output-buffer read uses a one-line cache (tag 7 bits + valid); hit SHALL return PRDATA=line[32*PADDR[4:2]+:32] with zero wait states.
REQ-018 Miss FSM IDLE->CAPT->IDLE: IDLE access-phase miss drives PREADY=0, dout_rd_en=1, dout_rd_addr=PADDR[11:5]; CAPT drives PREADY=0, captures dout_rd_data, sets tag/valid; next cycle hits, so a miss costs exactly 2 wait states.
REQ-019 If PSEL drops during CAPT the capture SHALL still complete; no other effect.
REQ-020 Ctrl +0 write: cell_col=PWDATA[7:0], cell_row=PWDATA[15:8]; readback returns same.
REQ-021 Ctrl +4 write with PWDATA[0]=1: call pulses one cycle, busy<=1, done<=0, cache valid<=0; PWDATA[0]=0 no effect; reads return 0.
REQ-022 ret pulse: busy<=0, done<=1; ret and call-write in the same cycle: call wins.
REQ-023 Ctrl +8 read returns {30'b0, busy, done}.
REQ-024 Ctrl +C bit0 = irq_en (read/write); irq = done & irq_en, registered-free combinational.
REQ-025 Reads of INSTR and DATA_IN windows SHALL return 0, PSLVERR=0.

Reset
REQ-026 reset_int=1 SHALL asynchronously force: FSM IDLE, PREADY=1, PSLVERR=0, PRDATA=0, all enables and call 0, cell_row/col 0, staging 0, cache invalid, busy 0, done 0, irq_en 0, irq 0.
REQ-027 Reset during a miss wait SHALL abort it; after release the first read of that line misses again.

Verification
REQ-028 Write 32'h0000_0302 to CTRL+0, then PWDATA 32'hDEAD_BEEF to INSTR+8 -> cell_row=3, cell_col=2, instr_wr_en one cycle with addr 2, data DEADBEEF.
REQ-029 Write words 0..7 (values 1..8) to DATA_IN+0x40..0x5C -> single din_wr_en, addr 2, data {8,7,...,1}; then rewrite only +0x5C with 9 -> recommit {9,7,...,1}.
REQ-030 Read DATA_OUT+0x24 with line 1 = 256'h...; -> 2 wait states, one dout_rd_en addr 1, PRDATA word 1; read +0x28 next -> 0 wait states, word 2.
REQ-031 Write 1 to CTRL+4 -> call one cycle, status=2'b10, cache invalid; pulse ret -> status=2'b01; with irq_en=1 irq=1; repeat read of DATA_OUT+0x24 misses.
REQ-032 Write to DATA_OUT+0, write to CTRL+8, access 32'h0000_4000 -> PSLVERR=1, no outputs change.
REQ-033 Assert reset_int in CAPT -> PREADY=1 immediately, all REQ-026 values, next read misses.

Source files
------------

// File: rtl/kth_apb_responder.sv
// kth_apb_responder: APB3 slave bridging a CPU to a fabric's instruction memory,
// input line buffer, output line buffer (one-line read cache) and control words.
module kth_apb_responder #(
  parameter logic [31:0] INSTR_BASE_ADDR    = 32'h0000_0000,
  parameter logic [31:0] DATA_IN_BASE_ADDR  = 32'h0000_1000,
  parameter logic [31:0] DATA_OUT_BASE_ADDR = 32'h0000_2000,
  parameter logic [31:0] CTRL_BASE_ADDR     = 32'h0000_3000
) (
  input  logic         clk_in,
  input  logic         reset_int,
  input  logic [31:0]  PADDR,
  input  logic         PSEL,
  input  logic         PENABLE,
  input  logic         PWRITE,
  input  logic [31:0]  PWDATA,
  output logic [31:0]  PRDATA,
  output logic         PREADY,
  output logic         PSLVERR,
  output logic         instr_wr_en,
  output logic [9:0]   instr_wr_addr,
  output logic [31:0]  instr_wr_data,
  output logic [7:0]   cell_row,
  output logic [7:0]   cell_col,
  output logic         din_wr_en,
  output logic [6:0]   din_wr_addr,
  output logic [255:0] din_wr_data,
  output logic         dout_rd_en,
  output logic [6:0]   dout_rd_addr,
  input  logic [255:0] dout_rd_data,
  output logic         call,
  input  logic         ret,
  output logic         irq
);
  typedef enum logic {IDLE, CAPT} state_e;
  state_e state_q, state_d;
  logic [7:0] cell_row_q, cell_col_q;
  logic [255:0] stage_q, line_q;
  logic [6:0] din_addr_q, tag_q;
  logic din_en_q, valid_q, call_q, busy_q, done_q, irq_en_q;
  logic act, in_instr, in_din, in_dout, in_ctrl, err, hit, miss, wr, call_wr;
  logic [31:0] ctrl_rd;
  logic unused_ok;
  assign unused_ok = &{1'b0, PADDR[1:0]};
  // Reset gates every bus-facing output through act.
  assign act = PSEL & PENABLE & ~reset_int;
  assign in_instr = PADDR[31:12] == INSTR_BASE_ADDR[31:12];
  assign in_din = PADDR[31:12] == DATA_IN_BASE_ADDR[31:12];
  assign in_dout = PADDR[31:12] == DATA_OUT_BASE_ADDR[31:12];
  assign in_ctrl = PADDR[31:4] == CTRL_BASE_ADDR[31:4];
  assign err = ~(in_instr | in_din | in_dout | in_ctrl) | (PWRITE & (in_dout | (in_ctrl & PADDR[3:2] == 2'd2)));
  assign hit = valid_q & (tag_q == PADDR[11:5]);
  assign miss = act & in_dout & ~PWRITE & ~hit & (state_q == IDLE);
  assign wr = act & PREADY & PWRITE & ~err;
  assign call_wr = wr & in_ctrl & (PADDR[3:2] == 2'd1) & PWDATA[0];
  always_ff @(posedge clk_in or posedge reset_int) begin
    if (reset_int) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == CAPT) ? IDLE : (miss ? CAPT : IDLE);
  end
  always_comb begin
    ctrl_rd = (PADDR[3:2] == 2'd0) ? {16'b0, cell_row_q, cell_col_q} :
              (PADDR[3:2] == 2'd2) ? {30'b0, busy_q, done_q} :
              (PADDR[3:2] == 2'd3) ? {31'b0, irq_en_q} : 32'b0;
    PREADY = ~(miss | (state_q == CAPT));
    PSLVERR = act & err;
    PRDATA = (~act | err) ? 32'b0 :
             in_dout ? (hit ? line_q[32*PADDR[4:2] +: 32] : 32'b0) :
             in_ctrl ? ctrl_rd : 32'b0;
    dout_rd_en = miss;
    dout_rd_addr = PADDR[11:5];
    instr_wr_en = wr & in_instr;
    instr_wr_addr = PADDR[11:2];
    instr_wr_data = PWDATA;
  end
  always_ff @(posedge clk_in or posedge reset_int) begin
    if (reset_int) begin
      cell_row_q <= '0;
      cell_col_q <= '0;
      stage_q <= '0;
      line_q <= '0;
      din_addr_q <= '0;
      tag_q <= '0;
      din_en_q <= 1'b0;
      valid_q <= 1'b0;
      call_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      din_en_q <= wr & in_din & (PADDR[4:2] == 3'd7);
      call_q <= call_wr;
      if (wr & in_din) stage_q[32*PADDR[4:2] +: 32] <= PWDATA;
      if (wr & in_din & (PADDR[4:2] == 3'd7)) din_addr_q <= PADDR[11:5];
      if (wr & in_ctrl & (PADDR[3:2] == 2'd0)) {cell_row_q, cell_col_q} <= PWDATA[15:0];
      if (wr & in_ctrl & (PADDR[3:2] == 2'd3)) irq_en_q <= PWDATA[0];
      if (call_wr) begin
        busy_q <= 1'b1;
        done_q <= 1'b0;
      end else if (ret) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
      // Tag is claimed at the miss; the line becomes valid only once captured.
      if (miss) begin
        tag_q <= PADDR[11:5];
        valid_q <= 1'b0;
      end
      if (state_q == CAPT) begin
        line_q <= dout_rd_data;
        valid_q <= 1'b1;
      end
      if (call_wr) valid_q <= 1'b0;
    end
  end
  assign cell_row = cell_row_q;
  assign cell_col = cell_col_q;
  assign din_wr_en = din_en_q;
  assign din_wr_addr = din_addr_q;
  assign din_wr_data = stage_q;
  assign call = call_q;
  assign irq = done_q & irq_en_q;
endmodule

// File: tb/tb_kth_apb_responder.sv
// tb_kth_apb_responder: directed vector table plus hand sequences for the
// cache miss, input-line commit, call/ret and reset-abort corner cases.
module tb_kth_apb_responder;
  localparam logic [31:0] IB = 32'h0000_0000, DI = 32'h0000_1000, DO = 32'h0000_2000, CB = 32'h0000_3000;
  logic clk_in = 1'b0, reset_int = 1'b1;
  logic [31:0] PADDR = '0, PWDATA = '0, PRDATA;
  logic PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0, PREADY, PSLVERR;
  logic instr_wr_en, din_wr_en, dout_rd_en, call, irq, ret = 1'b0;
  logic [9:0] instr_wr_addr;
  logic [31:0] instr_wr_data;
  logic [7:0] cell_row, cell_col;
  logic [6:0] din_wr_addr, dout_rd_addr;
  logic [255:0] din_wr_data, dout_rd_data = '0;
  int n_cmp = 0, n_err = 0;
  int instr_cnt = 0, din_cnt = 0, dout_cnt = 0, call_cnt = 0;
  logic [9:0] instr_a;
  logic [31:0] instr_d;
  logic [6:0] din_a, dout_a;
  logic [255:0] din_d;

  kth_apb_responder dut (
    .clk_in(clk_in), .reset_int(reset_int), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .instr_wr_en(instr_wr_en), .instr_wr_addr(instr_wr_addr), .instr_wr_data(instr_wr_data),
    .cell_row(cell_row), .cell_col(cell_col), .din_wr_en(din_wr_en), .din_wr_addr(din_wr_addr),
    .din_wr_data(din_wr_data), .dout_rd_en(dout_rd_en), .dout_rd_addr(dout_rd_addr),
    .dout_rd_data(dout_rd_data), .call(call), .ret(ret), .irq(irq)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [255:0] line_of(input logic [6:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = 32'hA000_0000 | (32'(a) << 8) | 32'(k);
    return l;
  endfunction

  always @(posedge clk_in) begin
    if (instr_wr_en) begin
      instr_cnt <= instr_cnt + 1;
      instr_a <= instr_wr_addr;
      instr_d <= instr_wr_data;
    end
    if (din_wr_en) begin
      din_cnt <= din_cnt + 1;
      din_a <= din_wr_addr;
      din_d <= din_wr_data;
    end
    if (dout_rd_en) begin
      dout_cnt <= dout_cnt + 1;
      dout_a <= dout_rd_addr;
      dout_rd_data <= line_of(dout_rd_addr);
    end
    if (call) call_cnt <= call_cnt + 1;
  end

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic apb(input logic [31:0] a, input logic w, input logic [31:0] d,
                     output logic [31:0] rd, output logic er, output int waits);
    @(negedge clk_in);
    PADDR = a; PWRITE = w; PWDATA = d; PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge clk_in);
    PENABLE = 1'b1;
    waits = 0;
    #1;
    while (!PREADY && waits < 8) begin
      waits++;
      @(negedge clk_in);
      #1;
    end
    chk("pready_timeout", PREADY, 1'b1);
    rd = PRDATA;
    er = PSLVERR;
    @(posedge clk_in);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk_in);
    #1;
  endtask

  typedef struct {
    logic [31:0] a;
    logic w;
    logic [31:0] d;
    logic [31:0] er;
    logic ee;
  } vec_t;

  initial begin
    vec_t tv[14];
    logic [31:0] rd;
    logic er;
    int wt, c0;
    logic [255:0] exp_line;
    tv[0]  = '{CB + 32'h0, 1'b1, 32'h0000_0302, 32'h0, 1'b0};
    tv[1]  = '{CB + 32'h0, 1'b0, 32'h0, 32'h0000_0302, 1'b0};
    tv[2]  = '{CB + 32'h4, 1'b0, 32'h0, 32'h0, 1'b0};
    tv[3]  = '{CB + 32'h8, 1'b0, 32'h0, 32'h0, 1'b0};
    tv[4]  = '{CB + 32'h4, 1'b1, 32'h0, 32'h0, 1'b0};
    tv[5]  = '{CB + 32'hC, 1'b1, 32'h1, 32'h0, 1'b0};
    tv[6]  = '{CB + 32'hC, 1'b0, 32'h0, 32'h1, 1'b0};
    tv[7]  = '{IB + 32'h8, 1'b0, 32'h0, 32'h0, 1'b0};
    tv[8]  = '{DI + 32'h40, 1'b0, 32'h0, 32'h0, 1'b0};
    tv[9]  = '{DO + 32'h0, 1'b1, 32'h1234, 32'h0, 1'b1};
    tv[10] = '{CB + 32'h8, 1'b1, 32'h3, 32'h0, 1'b1};
    tv[11] = '{32'h0000_4000, 1'b0, 32'h0, 32'h0, 1'b1};
    tv[12] = '{32'h0000_4000, 1'b1, 32'hFF, 32'h0, 1'b1};
    tv[13] = '{CB + 32'h10, 1'b0, 32'h0, 32'h0, 1'b1};
    PSEL = 1'b1; PENABLE = 1'b1; PADDR = DO + 32'h24;
    #3;
    chk("rst_pready", PREADY, 1'b1);
    chk("rst_pslverr", PSLVERR, 1'b0);
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_dout_rd_en", dout_rd_en, 1'b0);
    chk("rst_call_irq", {call, irq}, 2'b00);
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    reset_int = 1'b0;
    for (int i = 0; i < 14; i++) begin
      apb(tv[i].a, tv[i].w, tv[i].d, rd, er, wt);
      chk($sformatf("vec%0d_prdata", i), rd, tv[i].er);
      chk($sformatf("vec%0d_pslverr", i), er, tv[i].ee);
      chk($sformatf("vec%0d_waits", i), wt, 0);
    end
    settle();
    chk("err_no_side_effects", {instr_cnt, din_cnt, dout_cnt, call_cnt}, 128'h0);
    chk("cell_row_col", {cell_row, cell_col}, 16'h0302);
    apb(IB + 32'h8, 1'b1, 32'hDEAD_BEEF, rd, er, wt);
    settle();
    chk("instr_cnt", instr_cnt, 1);
    chk("instr_addr", instr_a, 10'd2);
    chk("instr_data", instr_d, 32'hDEAD_BEEF);
    for (int k = 0; k < 8; k++) begin
      apb(DI + 32'h40 + 32'(4*k), 1'b1, 32'(k + 1), rd, er, wt);
      if (k == 6) chk("din_no_early_commit", din_cnt, 0);
    end
    settle();
    for (int k = 0; k < 8; k++) exp_line[32*k +: 32] = 32'(k + 1);
    chk("din_cnt1", din_cnt, 1);
    chk("din_addr", din_a, 7'd2);
    chk("din_data", din_d, exp_line);
    apb(DI + 32'h5C, 1'b1, 32'd9, rd, er, wt);
    settle();
    exp_line[255:224] = 32'd9;
    chk("din_cnt2", din_cnt, 2);
    chk("din_recommit", din_d, exp_line);
    exp_line = line_of(7'd1);
    apb(DO + 32'h24, 1'b0, 32'h0, rd, er, wt);
    chk("miss_waits", wt, 2);
    chk("miss_rd_cnt", dout_cnt, 1);
    chk("miss_rd_addr", dout_a, 7'd1);
    chk("miss_prdata", rd, exp_line[63:32]);
    apb(DO + 32'h28, 1'b0, 32'h0, rd, er, wt);
    chk("hit_waits", wt, 0);
    chk("hit_prdata", rd, exp_line[95:64]);
    chk("hit_no_rd", dout_cnt, 1);
    apb(CB + 32'h4, 1'b1, 32'h1, rd, er, wt);
    settle();
    chk("call_cnt", call_cnt, 1);
    apb(CB + 32'h8, 1'b0, 32'h0, rd, er, wt);
    chk("status_busy", rd, 32'h2);
    chk("irq_busy", irq, 1'b0);
    @(negedge clk_in);
    ret = 1'b1;
    @(negedge clk_in);
    ret = 1'b0;
    apb(CB + 32'h8, 1'b0, 32'h0, rd, er, wt);
    chk("status_done", rd, 32'h1);
    chk("irq_done", irq, 1'b1);
    c0 = dout_cnt;
    apb(DO + 32'h24, 1'b0, 32'h0, rd, er, wt);
    chk("inval_waits", wt, 2);
    chk("inval_rd_cnt", dout_cnt - c0, 1);
    chk("inval_prdata", rd, exp_line[63:32]);
    @(negedge clk_in);
    PADDR = DO + 32'h44; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge clk_in);
    PENABLE = 1'b1;
    #1;
    chk("abort_miss_rd_en", {dout_rd_en, PREADY}, 2'b10);
    @(negedge clk_in);
    #1;
    chk("abort_capt_pready", PREADY, 1'b0);
    reset_int = 1'b1;
    #1;
    chk("abort_pready", PREADY, 1'b1);
    chk("abort_pslverr_prdata", {PSLVERR, PRDATA}, 33'h0);
    chk("abort_outs", {call, irq, instr_wr_en, din_wr_en, dout_rd_en}, 5'b0);
    chk("abort_cell", {cell_row, cell_col}, 16'h0);
    chk("abort_staging", din_wr_data, 256'h0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    reset_int = 1'b0;
    apb(CB + 32'h8, 1'b0, 32'h0, rd, er, wt);
    chk("post_rst_status", rd, 32'h0);
    apb(CB + 32'hC, 1'b0, 32'h0, rd, er, wt);
    chk("post_rst_irq_en", rd, 32'h0);
    exp_line = line_of(7'd2);
    apb(DO + 32'h44, 1'b0, 32'h0, rd, er, wt);
    chk("post_rst_waits", wt, 2);
    chk("post_rst_prdata", rd, exp_line[63:32]);
    apb(DI + 32'h1C, 1'b1, 32'd5, rd, er, wt);
    settle();
    chk("post_rst_din", din_d, {32'd5, 224'h0});
    ret = 1'b1;
    apb(CB + 32'h4, 1'b1, 32'h1, rd, er, wt);
    ret = 1'b0;
    apb(CB + 32'h8, 1'b0, 32'h0, rd, er, wt);
    chk("call_beats_ret", rd, 32'h2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
